// File: rtl/alert_collector.sv
// alert_collector: per-packet match de-duplicator and alert record emitter.
// A collect bank gathers distinct pattern IDs for the open packet. At the
// (delayed) packet close, its contents move to the emit bank, which drives
// a header word plus one word per ID on a valid/ready stream while the next
// packet is already being collected.
module alert_collector #(
  parameter int ID_W      = 11,
  parameter int FLOW_W    = 7,
  parameter int MAX_IDS   = 16,
  parameter int EOP_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   real_patternID,
  input  logic [FLOW_W-1:0] flow,
  input  logic              end_of_packet,
  output logic [15:0]       alert_data,
  output logic              alert_valid,
  output logic              alert_last,
  input  logic              alert_ready,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_IDS + 1);
  localparam int IDX_W = (MAX_IDS > 1) ? $clog2(MAX_IDS) : 1;

  typedef enum logic [1:0] {E_IDLE, E_HDR, E_ID} estate_e;

  // ---------------------------------------------------------------------
  // End-of-packet delay line (aligns the close with the combine pipeline)
  // ---------------------------------------------------------------------
  logic eop_d;

  generate
    if (EOP_DELAY == 0) begin : g_no_dly
      assign eop_d = end_of_packet;
    end else begin : g_dly
      logic [EOP_DELAY-1:0] eop_pipe_q;
      // Shift register; every pulse travels through independently.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) eop_pipe_q <= '0;
        else        eop_pipe_q <= (eop_pipe_q << 1) | EOP_DELAY'(end_of_packet);
      end
      assign eop_d = eop_pipe_q[EOP_DELAY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Collect bank
  // ---------------------------------------------------------------------
  logic [MAX_IDS-1:0][ID_W-1:0] col_ids_q, col_ids_d;
  logic [CNT_W-1:0]             col_cnt_q, col_cnt_d;
  logic                         col_trunc_q, col_trunc_d;
  logic [MAX_IDS-1:0]           hit;
  logic                         new_id, room, cap, ovf;

  // One comparator per slot; only occupied slots may report a duplicate.
  generate
    for (genvar i = 0; i < MAX_IDS; i++) begin : g_cmp
      assign hit[i] = (CNT_W'(i) < col_cnt_q) && (col_ids_q[i] == real_patternID);
    end
  endgenerate

  assign new_id = (real_patternID != '0) && !(|hit);
  assign room   = (col_cnt_q < CNT_W'(MAX_IDS));
  assign cap    = new_id && room;
  assign ovf    = new_id && !room;

  // Bank contents including this cycle's capture (a capture on the close
  // cycle belongs to the closing packet).
  always_comb begin
    col_ids_d   = col_ids_q;
    col_cnt_d   = col_cnt_q + CNT_W'(cap);
    col_trunc_d = col_trunc_q | ovf;
    for (int i = 0; i < MAX_IDS; i++) begin
      if (cap && (col_cnt_q == CNT_W'(i))) col_ids_d[i] = real_patternID;
    end
  end

  // ---------------------------------------------------------------------
  // Close decision
  // ---------------------------------------------------------------------
  estate_e          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pkt_empty, last_hs, emit_free, swap, drop;

  assign pkt_empty = (col_cnt_d == '0) && !col_trunc_d;
  assign last_hs   = alert_valid && alert_ready && alert_last;
  assign emit_free = (state_q == E_IDLE) || last_hs;
  assign swap      = eop_d && !pkt_empty && emit_free;
  assign drop      = eop_d && !pkt_empty && !emit_free;

  // Collect bank register: cleared at every close, otherwise accumulates.
  // Slots past cnt are don't-care, so only cnt/trunc are cleared at close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_ids_q   <= '0;
      col_cnt_q   <= '0;
      col_trunc_q <= 1'b0;
    end else if (eop_d) begin
      col_cnt_q   <= '0;
      col_trunc_q <= 1'b0;
    end else begin
      col_ids_q   <= col_ids_d;
      col_cnt_q   <= col_cnt_d;
      col_trunc_q <= col_trunc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Emit bank: loaded only on swap, so it is stable for the whole record.
  // ---------------------------------------------------------------------
  logic [MAX_IDS-1:0][ID_W-1:0] emit_ids_q;
  logic [CNT_W-1:0]             emit_cnt_q;
  logic                         emit_trunc_q;
  logic [FLOW_W-1:0]            emit_flow_q;

  // Emit bank load at swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emit_ids_q   <= '0;
      emit_cnt_q   <= '0;
      emit_trunc_q <= 1'b0;
      emit_flow_q  <= '0;
    end else if (swap) begin
      emit_ids_q   <= col_ids_d;
      emit_cnt_q   <= col_cnt_d;
      emit_trunc_q <= col_trunc_d;
      emit_flow_q  <= flow;
    end
  end

  // Saturating count of records discarded while the emitter was busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       drop_cnt <= '0;
    else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 16'd1;
  end

  // ---------------------------------------------------------------------
  // Emitter FSM
  // ---------------------------------------------------------------------
  // State and word index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= E_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and stream outputs; words depend only on registers, so they
  // are stable while the sink stalls.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    alert_valid = 1'b0;
    alert_last  = 1'b0;
    alert_data  = '0;
    case (state_q)
      E_IDLE: begin
        if (swap) state_d = E_HDR;
      end
      E_HDR: begin
        alert_valid = 1'b1;
        alert_data  = {1'b1, emit_trunc_q, 7'(emit_flow_q), 7'(emit_cnt_q)};
        if (alert_ready) begin
          state_d = E_ID;
          idx_d   = '0;
        end
      end
      E_ID: begin
        alert_valid = 1'b1;
        alert_data  = 16'(emit_ids_q[idx_q]);
        alert_last  = (CNT_W'(idx_q) + CNT_W'(1) == emit_cnt_q);
        if (alert_ready) begin
          if (alert_last) state_d = swap ? E_HDR : E_IDLE;
          else            idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = E_IDLE;
    endcase
  end

  assign busy = (state_q != E_IDLE);

endmodule

// File: tb/tb_alert_collector.sv
// Randomized and directed bench for alert_collector, checked every cycle
// against a record-level reference model (ID lists, word queue, words-left).
module tb_alert_collector;
  localparam int ID_W = 11, FLOW_W = 7, MAX_IDS = 16, EOP_DELAY = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ID_W-1:0]   pid;
  logic [FLOW_W-1:0] flow;
  logic              eop, rdy;
  logic [15:0]       alert_data, drop_cnt;
  logic              alert_valid, alert_last, busy;

  int n_chk = 0, n_pass = 0;

  // reference model state
  int          col_q[$];
  bit          col_trunc;
  int          exp_q[$];
  int          wl;
  int          drop_m;
  int          close_q[$];
  int          cycn = 0;
  logic [15:0] last_hdr;

  alert_collector #(.ID_W(ID_W), .FLOW_W(FLOW_W), .MAX_IDS(MAX_IDS), .EOP_DELAY(EOP_DELAY)) dut (
    .clk(clk), .rst_n(rst_n), .real_patternID(pid), .flow(flow), .end_of_packet(eop),
    .alert_data(alert_data), .alert_valid(alert_valid), .alert_last(alert_last),
    .alert_ready(rdy), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_clear();
    col_q.delete(); col_trunc = 0; exp_q.delete(); wl = 0; drop_m = 0;
    close_q.delete(); last_hdr = '0;
  endtask

  // Compare outputs, advance the model with the current inputs, then clock.
  task automatic step();
    bit hs, lhs, free, found;
    int sz;
    chk("valid", alert_valid, wl > 0);
    chk("busy", busy, wl > 0);
    chk("drop_cnt", drop_cnt, drop_m);
    if (wl > 0) begin
      chk("data", alert_data, exp_q[0]);
      chk("last", alert_last, wl == 1);
    end
    hs   = (wl > 0) && rdy;
    lhs  = (wl == 1) && rdy;
    free = (wl == 0) || lhs;
    if (hs) begin
      if (exp_q[0] >= 32768) last_hdr = alert_data;
      void'(exp_q.pop_front());
      wl--;
    end
    if (pid != 0) begin
      found = 0;
      foreach (col_q[i]) if (col_q[i] == int'(pid)) found = 1;
      if (!found) begin
        if (col_q.size() < MAX_IDS) col_q.push_back(int'(pid));
        else col_trunc = 1;
      end
    end
    if (eop) close_q.push_back(cycn + EOP_DELAY);
    if (close_q.size() > 0 && close_q[0] == cycn) begin
      void'(close_q.pop_front());
      sz = col_q.size();
      if (sz > 0 || col_trunc) begin
        if (free) begin
          exp_q.push_back(32768 + (int'(col_trunc) << 14) + (int'(flow) << 7) + sz);
          foreach (col_q[i]) exp_q.push_back(col_q[i]);
          wl = sz + 1;
        end else if (drop_m < 65535) drop_m++;
      end
      col_q.delete();
      col_trunc = 0;
    end
    cycn++;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input int id, input bit e, input bit r);
    pid = ID_W'(id); eop = e; rdy = r;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pid = '0; eop = 1'b0; rdy = 1'b0;
    #1;
    chk("rst_valid", alert_valid, 0);
    chk("rst_last", alert_last, 0);
    chk("rst_data", alert_data, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;
  endtask

  initial begin
    int since;
    rst_n = 1'b0; pid = '0; flow = '0; eop = 1'b0; rdy = 1'b0;
    model_clear();
    #1;
    do_reset();

    // single packet
    flow = 7'd5;
    cyc(12, 0, 1); cyc(700, 0, 1); cyc(33, 0, 1); cyc(0, 1, 1);
    repeat (10) cyc(0, 0, 1);
    chk("hdr_single", last_hdr, 16'h8283);

    // duplicates and zeros
    flow = 7'd9;
    cyc(40, 0, 1); cyc(0, 0, 1); cyc(40, 0, 1); cyc(41, 0, 1); cyc(40, 0, 1); cyc(0, 1, 1);
    repeat (8) cyc(0, 0, 1);
    chk("hdr_dup", last_hdr, 16'h8482);

    // overflow
    flow = 7'd3;
    for (int i = 1; i <= 18; i++) cyc(i, 0, 1);
    cyc(0, 1, 1);
    repeat (24) cyc(0, 0, 1);
    chk("hdr_ovf", last_hdr, 16'hC190);

    // empty packet
    cyc(0, 1, 1);
    repeat (8) cyc(0, 0, 1);
    chk("empty_drop", drop_cnt, 0);

    // backpressure, drop, back-to-back
    flow = 7'd1;
    for (int i = 0; i < 10; i++) cyc(100 + i, 0, 1);
    cyc(0, 1, 1);
    for (int k = 0; k < 12 && wl == 0; k++) cyc(0, 0, k[0]);
    cyc(500, 0, 0); cyc(0, 1, 1);
    for (int k = 0; k < 5; k++) cyc(0, 0, k[0]);
    chk("drop_one", drop_cnt, 1);
    for (int k = 0; k < 40 && wl != EOP_DELAY + 1; k++) cyc(200 + k, 0, 1);
    cyc(0, 1, 1);
    repeat (20) cyc(0, 0, 1);
    chk("b2b_drop", drop_cnt, 1);

    // reset during ID emission, then a clean record
    flow = 7'd2;
    cyc(7, 0, 1); cyc(8, 0, 1); cyc(9, 0, 1); cyc(0, 1, 0);
    for (int k = 0; k < 12 && wl == 0; k++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    do_reset();
    cyc(21, 0, 1); cyc(22, 0, 1); cyc(0, 1, 1);
    repeat (8) cyc(0, 0, 1);
    chk("hdr_after_rst", last_hdr, 16'h8102);

    // random traffic
    since = 10;
    for (int k = 0; k < 1500; k++) begin
      bit e;
      e = (since >= 2) && ($urandom_range(0, 19) == 0);
      since = e ? 0 : since + 1;
      flow = FLOW_W'($urandom);
      cyc(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0, e, $urandom_range(0, 3) != 0);
    end
    repeat (40) cyc(0, 0, 1);
    chk("drain_idle", alert_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
